// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding and bit timing constants,
// used by both the transmitter and the oversampling receiver.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // s_ticks per start/data/parity bit (16x oversampling)
  localparam int unsigned TICKS_PER_BIT = 16;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB-first, optional parity,
// SB_TICK/16 stop bits. Bit timing from the shared 16x s_tick enable.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  output logic       tx_busy,
  output logic       tx_done_tick,
  output logic       tx
);

  // Tick counter must reach SB_TICK-1 in the stop state
  localparam int unsigned TW = (SB_TICK > TICKS_PER_BIT) ? 5 : 4;
  localparam logic [TW-1:0] BIT_LAST  = TW'(TICKS_PER_BIT - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [2:0]    DBIT_LAST = 3'(DBIT - 1);
  localparam logic          ODD_BIT   = (PARITY_ODD != 0);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);

  uart_state_e   state;
  logic [TW-1:0] tick_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          par_q;

  // Frame sequencer; tx and tx_busy are loaded with the value belonging to
  // the state being entered, so the line follows the state register exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_start) begin
            state   <= ST_START;
            shift_q <= data_in;
            tick_q  <= '0;
            par_q   <= 1'b0;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end
        end

        ST_START: begin
          if (s_tick) begin
            if (tick_q == BIT_LAST) begin
              tick_q <= '0;
              bit_q  <= '0;
              state  <= ST_DATA;
              tx     <= shift_q[0];
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (s_tick) begin
            if (tick_q == BIT_LAST) begin
              tick_q  <= '0;
              shift_q <= shift_q >> 1;
              par_q   <= par_q ^ shift_q[0];
              if (bit_q == DBIT_LAST) begin
                if (HAS_PAR) begin
                  state <= ST_PARITY;
                  // parity including the bit leaving now
                  tx    <= par_q ^ shift_q[0] ^ ODD_BIT;
                end else begin
                  state <= ST_STOP;
                  tx    <= 1'b1;
                end
              end else begin
                bit_q <= bit_q + 1'b1;
                tx    <= shift_q[1];
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end

        ST_PARITY: begin
          if (s_tick) begin
            if (tick_q == BIT_LAST) begin
              tick_q <= '0;
              state  <= ST_STOP;
              tx     <= 1'b1;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (s_tick) begin
            if (tick_q == STOP_LAST) begin
              tick_q       <= '0;
              state        <= ST_IDLE;
              tx_done_tick <= 1'b1;
              tx_busy      <= 1'b0;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end

        default: begin
          state   <= ST_IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three differently parameterised instances share one
// s_tick and are checked every cycle against a tick-count frame model.
module tb_uart_tx;

  localparam int NDUT = 3;
  localparam int CFG_DBIT [NDUT] = '{8, 7, 8};
  localparam int CFG_SB   [NDUT] = '{16, 24, 32};
  localparam int CFG_PAR  [NDUT] = '{0, 1, 1};
  localparam int CFG_ODD  [NDUT] = '{0, 0, 1};

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            s_tick = 1'b0;
  logic [NDUT-1:0] tx_start = '0;
  logic [7:0]      data_in [NDUT];
  logic [NDUT-1:0] tx, busy, done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start[0]),
    .data_in(data_in[0]), .tx_busy(busy[0]), .tx_done_tick(done[0]), .tx(tx[0]));
  uart_tx #(.DBIT(7), .SB_TICK(24), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start[1]),
    .data_in(data_in[1]), .tx_busy(busy[1]), .tx_done_tick(done[1]), .tx(tx[1]));
  uart_tx #(.DBIT(8), .SB_TICK(32), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start[2]),
    .data_in(data_in[2]), .tx_busy(busy[2]), .tx_done_tick(done[2]), .tx(tx[2]));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is a list of segments: start, data bits, parity, stop.
  // The line value after n consumed s_ticks is the segment n/16.
  int         m_busy [NDUT];
  int         m_tick [NDUT];
  logic [7:0] m_data [NDUT];
  logic       m_tx   [NDUT];
  logic       m_done [NDUT];

  function automatic int frame_len(input int i);
    return 16 * (1 + CFG_DBIT[i] + CFG_PAR[i]) + CFG_SB[i];
  endfunction

  function automatic logic frame_bit(input int i, input int t);
    int k;
    logic [7:0] mask;
    k = t / 16;
    mask = 8'((1 << CFG_DBIT[i]) - 1);
    if (k == 0) return 1'b0;
    if (k <= CFG_DBIT[i]) return m_data[i][k-1];
    if (CFG_PAR[i] != 0 && k == CFG_DBIT[i] + 1)
      return (^(m_data[i] & mask)) ^ (CFG_ODD[i] != 0);
    return 1'b1;
  endfunction

  initial begin
    for (int i = 0; i < NDUT; i++) begin
      m_busy[i] = 0; m_tick[i] = 0; m_data[i] = '0;
      m_tx[i] = 1'b1; m_done[i] = 1'b0; data_in[i] = '0;
    end
  end

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < NDUT; i++) begin
      m_done[i] = 1'b0;
      if (reset) begin
        m_busy[i] = 0; m_tick[i] = 0; m_tx[i] = 1'b1;
      end else if (m_busy[i] == 0) begin
        if (tx_start[i]) begin
          m_busy[i] = 1; m_tick[i] = 0; m_data[i] = data_in[i]; m_tx[i] = 1'b0;
        end
      end else if (s_tick) begin
        m_tick[i]++;
        if (m_tick[i] == frame_len(i)) begin
          m_busy[i] = 0; m_done[i] = 1'b1; m_tx[i] = 1'b1;
        end else begin
          m_tx[i] = frame_bit(i, m_tick[i]);
        end
      end
    end
  end

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NDUT; i++) begin
        chk($sformatf("dut%0d.tx", i), int'(tx[i]), int'(m_tx[i]));
        chk($sformatf("dut%0d.busy", i), int'(busy[i]), m_busy[i]);
        chk($sformatf("dut%0d.done", i), int'(done[i]), int'(m_done[i]));
      end
    end
  end

  // ---------------- measurements ----------------
  int   done_cnt [NDUT] = '{0, 0, 0};
  int   rise_cyc = 0;
  int   stop_len = -1;
  logic prev_tx2 = 1'b1;

  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) if (done[i] === 1'b1) done_cnt[i]++;
    if (tx[2] === 1'b1 && prev_tx2 === 1'b0) rise_cyc = cyc;
    if (done[2] === 1'b1) stop_len = cyc - rise_cyc;
    prev_tx2 = tx[2];
  end

  // ---------------- s_tick source ----------------
  int tick_mode = 0;  // 0: every 4 clk, 1: random, 2: held low
  int phase = 0;
  always @(negedge clk) begin
    case (tick_mode)
      0: begin phase = (phase + 1) % 4; s_tick = (phase == 0); end
      1: s_tick = ($urandom_range(0, 2) == 0);
      default: s_tick = 1'b0;
    endcase
  end

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (busy !== '0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy !== '0) begin
      bad++;
      $display("FAIL %s: still busy after %0d cycles (busy=%b)", name, limit, busy);
    end
    @(negedge clk);
  endtask

  // Start all three instances, probe dut0 mid-bit, probe parity bits,
  // and try an ignored 0xFF request during the data phase.
  task automatic frame_check(input logic [7:0] b0, input logic [9:0] exp0);
    int d0 [NDUT];
    for (int i = 0; i < NDUT; i++) d0[i] = done_cnt[i];
    stop_len = -1;
    @(negedge clk);
    data_in[0] = b0; data_in[1] = 8'h07; data_in[2] = 8'h07;
    tx_start = '1;
    @(negedge clk);
    tx_start = '0;
    for (int i = 0; i < NDUT; i++) data_in[i] = 8'($urandom);
    repeat (31) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      if (k < 10) chk($sformatf("dut0 bit %0d of %h", k, b0), int'(tx[0]), int'(exp0[k]));
      if (k == 8) chk("dut1 even parity of 07", int'(tx[1]), 1);
      if (k == 9) chk("dut2 odd parity of 07", int'(tx[2]), 0);
      if (k == 4) begin
        data_in[0] = 8'hFF; data_in[1] = 8'hFF; data_in[2] = 8'hFF;
        tx_start = '1;
        @(negedge clk);
        tx_start = '0;
        repeat (63) @(negedge clk);
      end else begin
        repeat (64) @(negedge clk);
      end
    end
    wait_idle("frame timeout", 2000);
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("dut%0d done pulses", i), done_cnt[i] - d0[i], 1);
    chk("dut2 stop length clk", stop_len, 128);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0, n;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("reset dut%0d.tx", i), int'(tx[i]), 1);
      chk($sformatf("reset dut%0d.busy", i), int'(busy[i]), 0);
      chk($sformatf("reset dut%0d.done", i), int'(done[i]), 0);
    end
    chk_en = 1'b1;
    reset = 1'b0;

    frame_check(8'h55, 10'b1010101010);
    frame_check(8'h00, 10'b1000000000);

    // back-to-back frames on dut0
    d0 = done_cnt[0];
    @(negedge clk);
    data_in[0] = 8'hA5; tx_start[0] = 1'b1;
    @(negedge clk);
    tx_start[0] = 1'b0;
    n = 0;
    while (done[0] !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    chk("a5 done seen", int'(done[0]), 1);
    data_in[0] = 8'h3C; tx_start[0] = 1'b1;
    @(negedge clk);
    tx_start[0] = 1'b0;
    chk("3c accepted busy", int'(busy[0]), 1);
    chk("3c start bit", int'(tx[0]), 0);
    wait_idle("back-to-back timeout", 2000);
    chk("back-to-back done pulses", done_cnt[0] - d0, 2);

    // reset in the middle of data bit 3
    d0 = done_cnt[0];
    data_in[0] = 8'h5A; tx_start[0] = 1'b1;
    @(negedge clk);
    tx_start[0] = 1'b0;
    repeat (32 + 64 * 4 - 1) @(negedge clk);
    chk("busy before abort", int'(busy[0]), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort tx", int'(tx[0]), 1);
    chk("abort busy", int'(busy[0]), 0);
    chk("abort done", int'(done[0]), 0);
    repeat (20) @(negedge clk);
    chk("abort no done pulse", done_cnt[0] - d0, 0);
    data_in[0] = 8'hC3; tx_start[0] = 1'b1;
    @(negedge clk);
    tx_start[0] = 1'b0;
    wait_idle("clean frame timeout", 2000);
    chk("clean frame done pulse", done_cnt[0] - d0, 1);

    // random traffic, random tick spacing, and a long tick-free stretch
    tick_mode = 1;
    for (int c = 0; c < 8000; c++) begin
      if (c == 3000) tick_mode = 2;
      if (c == 3300) tick_mode = 1;
      for (int i = 0; i < NDUT; i++) begin
        tx_start[i] = ($urandom_range(0, 99) < 3);
        data_in[i] = 8'($urandom);
      end
      @(negedge clk);
    end
    tx_start = '0;
    tick_mode = 0;
    wait_idle("random drain timeout", 4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
